// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: walks FETCH/DECODE/EXEC/MEM/WB, handshakes with
// variable-latency instruction and data memories, and emits one-cycle datapath strobes.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_load,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             dec_comparator,
    input  logic             dec_pc_select,
    input  logic             dec_halt,
    input  logic             jump_ok,
    output logic             flag_we,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_we,
    output logic             pc_inc,
    output logic             pc_load_rel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_e;

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               step_mode_q, step_mode_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;
    logic               timeout_hit;

    // A zero MEM_TIMEOUT disables the check entirely.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        retire      = 1'b0;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        flag_we     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        pc_inc      = 1'b0;
        pc_load_rel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d     = S_FETCH;
                    step_mode_d = step & ~run;
                    wait_d      = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_halt)
                    state_d = S_HALT;
                else if (dec_mem_read && dec_mem_write)
                    state_d = S_ERROR;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                flag_we = dec_comparator;
                if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (dec_reg_write) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ready) begin
                    if (dec_mem_read && dec_reg_write)
                        state_d = S_WB;
                    else
                        retire = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase

        // Every completion path funnels through here so the PC strobe and count stay unique.
        if (retire) begin
            pc_load_rel = dec_pc_select & jump_ok;
            pc_inc      = ~(dec_pc_select & jump_ok);
            cnt_d       = cnt_q + CNT_W'(1);
            state_d     = (run && !step_mode_q) ? S_FETCH : S_IDLE;
            wait_d      = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            wait_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign error       = (state_q == S_ERROR);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: walks ALU, load, store, jump, step, halt,
// reset and timeout scenarios cycle by cycle against hand-computed strobes.
module tb_cpu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run, step;
    logic        imem_req, imem_ready, ir_load;
    logic        dec_mem_read, dec_mem_write, dec_reg_write;
    logic        dec_comparator, dec_pc_select, dec_halt, jump_ok;
    logic        flag_we, dmem_req, dmem_we, dmem_ready;
    logic        reg_we, pc_inc, pc_load_rel;
    logic [2:0]  state;
    logic        halted, error;
    logic [15:0] instr_count;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] IMEM = 8'h80, IR = 8'h40, FLAG = 8'h20, DREQ = 8'h10;
    localparam logic [7:0] DWE  = 8'h08, REG = 8'h04, INC = 8'h02, REL = 8'h01;

    logic [7:0] strb;
    assign strb = {imem_req, ir_load, flag_we, dmem_req, dmem_we, reg_we, pc_inc, pc_load_rel};

    cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .step(step),
        .imem_req(imem_req), .imem_ready(imem_ready), .ir_load(ir_load),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_comparator(dec_comparator),
        .dec_pc_select(dec_pc_select), .dec_halt(dec_halt), .jump_ok(jump_ok),
        .flag_we(flag_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .reg_we(reg_we), .pc_inc(pc_inc),
        .pc_load_rel(pc_load_rel), .state(state), .halted(halted),
        .error(error), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic [7:0] sb);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strb"}, 32'(strb), 32'(sb));
    endtask

    task automatic nxt();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; step = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_reg_write = 1'b0;
        dec_comparator = 1'b0; dec_pc_select = 1'b0; dec_halt = 1'b0; jump_ok = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk_st("rst", 3'd0, 8'h00);
        chk("rst.cnt", 32'(instr_count), 0);
        chk("rst.halted", 32'(halted), 0);
        chk("rst.error", 32'(error), 0);
        reset_n = 1'b1;

        // ALU op, back-to-back under run, then run drops mid-instruction
        run = 1'b1; dec_reg_write = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; #1;
        chk_st("alu.idle", 3'd0, 8'h00);
        nxt(); chk_st("alu.f", 3'd1, IMEM | IR);
        nxt(); chk_st("alu.d", 3'd2, 8'h00);
        nxt(); chk_st("alu.e", 3'd3, 8'h00);
        nxt(); chk_st("alu.w", 3'd5, REG | INC);
        chk("alu.cnt0", 32'(instr_count), 0);
        nxt(); chk_st("alu.f2", 3'd1, IMEM | IR);
        chk("alu.cnt1", 32'(instr_count), 1);
        run = 1'b0;
        nxt(); chk_st("alu.d2", 3'd2, 8'h00);
        nxt(); chk_st("alu.e2", 3'd3, 8'h00);
        nxt(); chk_st("alu.w2", 3'd5, REG | INC);
        nxt(); chk_st("alu.idle2", 3'd0, 8'h00);
        chk("alu.cnt2", 32'(instr_count), 2);
        nxt(); chk_st("alu.stay", 3'd0, 8'h00);

        // Load with dmem_ready delayed 3 cycles: F D E M M M M W
        dec_mem_read = 1'b1; dmem_ready = 1'b0; run = 1'b1; #1;
        nxt(); chk_st("ld.f", 3'd1, IMEM | IR);
        nxt(); chk_st("ld.d", 3'd2, 8'h00);
        run = 1'b0;
        nxt(); chk_st("ld.e", 3'd3, 8'h00);
        repeat (3) begin
            nxt(); chk_st("ld.mwait", 3'd4, DREQ);
        end
        nxt(); dmem_ready = 1'b1; #1;
        chk_st("ld.mrdy", 3'd4, DREQ);
        nxt(); chk_st("ld.w", 3'd5, REG | INC);
        nxt(); chk_st("ld.idle", 3'd0, 8'h00);
        chk("ld.cnt", 32'(instr_count), 3);
        dec_mem_read = 1'b0; dec_reg_write = 1'b0;

        // Taken jump, then not-taken compare+jump
        dec_pc_select = 1'b1; jump_ok = 1'b1; run = 1'b1; #1;
        nxt(); chk_st("jt.f", 3'd1, IMEM | IR);
        nxt(); chk_st("jt.d", 3'd2, 8'h00);
        run = 1'b0;
        nxt(); chk_st("jt.e", 3'd3, REL);
        nxt(); chk_st("jt.idle", 3'd0, 8'h00);
        chk("jt.cnt", 32'(instr_count), 4);
        jump_ok = 1'b0; dec_comparator = 1'b1; run = 1'b1; #1;
        nxt(); chk_st("jn.f", 3'd1, IMEM | IR);
        nxt(); chk_st("jn.d", 3'd2, 8'h00);
        run = 1'b0;
        nxt(); chk_st("jn.e", 3'd3, FLAG | INC);
        nxt(); chk("jn.cnt", 32'(instr_count), 5);
        dec_pc_select = 1'b0; dec_comparator = 1'b0;

        // Store with two fetch wait states
        dec_mem_write = 1'b1; imem_ready = 1'b0; run = 1'b1; #1;
        nxt(); chk_st("st.fw1", 3'd1, IMEM);
        nxt(); chk_st("st.fw2", 3'd1, IMEM);
        imem_ready = 1'b1; #1;
        chk_st("st.f", 3'd1, IMEM | IR);
        nxt(); chk_st("st.d", 3'd2, 8'h00);
        run = 1'b0;
        nxt(); chk_st("st.e", 3'd3, 8'h00);
        nxt(); chk_st("st.m", 3'd4, DREQ | DWE | INC);
        nxt(); chk_st("st.idle", 3'd0, 8'h00);
        chk("st.cnt", 32'(instr_count), 6);

        // Asynchronous reset in the middle of a MEM wait
        dmem_ready = 1'b0; run = 1'b1; #1;
        nxt(); nxt(); nxt();
        nxt(); chk_st("rm.mem", 3'd4, DREQ | DWE);
        reset_n = 1'b0; #1;
        chk_st("rm.rst", 3'd0, 8'h00);
        chk("rm.cnt", 32'(instr_count), 0);
        nxt();
        reset_n = 1'b1; run = 1'b0; dec_mem_write = 1'b0; dmem_ready = 1'b1; #1;

        // Single step with run low
        dec_reg_write = 1'b1; step = 1'b1; #1;
        nxt(); chk_st("sp.f", 3'd1, IMEM | IR);
        step = 1'b0;
        nxt(); chk_st("sp.d", 3'd2, 8'h00);
        nxt(); chk_st("sp.e", 3'd3, 8'h00);
        nxt(); chk_st("sp.w", 3'd5, REG | INC);
        nxt(); chk_st("sp.idle", 3'd0, 8'h00);
        chk("sp.cnt", 32'(instr_count), 1);
        nxt(); chk_st("sp.stay", 3'd0, 8'h00);

        // Halt is sticky regardless of run/step
        dec_halt = 1'b1; run = 1'b1; #1;
        nxt(); chk_st("hl.f", 3'd1, IMEM | IR);
        nxt(); chk_st("hl.d", 3'd2, 8'h00);
        nxt(); chk_st("hl.h", 3'd6, 8'h00);
        chk("hl.halted", 32'(halted), 1);
        step = 1'b1;
        nxt(); chk_st("hl.h2", 3'd6, 8'h00);
        chk("hl.halted2", 32'(halted), 1);
        chk("hl.cnt", 32'(instr_count), 1);

        reset_n = 1'b0; run = 1'b0; step = 1'b0; dec_halt = 1'b0; dec_reg_write = 1'b0;
        nxt();
        reset_n = 1'b1; imem_ready = 1'b0; run = 1'b1; #1;

        // Fetch timeout after 15 cycles, no ir_load ever
        nxt();
        for (int i = 0; i < 15; i++) begin
            chk_st("to.f", 3'd1, IMEM);
            nxt();
        end
        chk_st("to.err", 3'd7, 8'h00);
        chk("to.error", 32'(error), 1);
        chk("to.cnt", 32'(instr_count), 0);

        reset_n = 1'b0;
        nxt();
        reset_n = 1'b1; imem_ready = 1'b1; dec_mem_read = 1'b1; dec_mem_write = 1'b1; #1;

        // Conflicting read+write decode goes to ERROR
        nxt(); chk_st("de.f", 3'd1, IMEM | IR);
        nxt(); chk_st("de.d", 3'd2, 8'h00);
        nxt(); chk_st("de.err", 3'd7, 8'h00);
        chk("de.error", 32'(error), 1);
        nxt(); chk_st("de.err2", 3'd7, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU datapath. It replaces the free-running fetch/execute loop with an explicit state machine. The FSM steps through FETCH, DECODE, EXEC, MEM and WB, and issues one-cycle strobes for IR load, flag update, register write and PC update. It handshakes with instruction and data memories of variable latency, and supports run, single-step, halt and a memory-timeout error. Decoded control bits arrive from the existing control and jump units; the sequencer never decodes opcodes itself.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles for imem_ready/dmem_ready before ERROR; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.
- clock  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; continuous execution while high.
- step  in  1  level; sampled in IDLE, executes exactly one instruction.
- imem_req  out  1  instruction fetch request at current PC.
- imem_ready  in  1  fetch data valid this cycle.
- ir_load  out  1  load instruction register (one cycle).
- dec_mem_read, dec_mem_write, dec_reg_write, dec_comparator, dec_pc_select, dec_halt  in  1 each  decoded control of the instruction in IR.
- jump_ok  in  1  branch condition from the jump unit.
- flag_we  out  1  latch ZF/CF.
- dmem_req  out  1  data-memory access request.
- dmem_we  out  1  write qualifier; valid only with dmem_req.
- dmem_ready  in  1  access complete this cycle.
- reg_we  out  1  register-file write strobe.
- pc_inc  out  1  PC <= PC + 1.
- pc_load_rel  out  1  PC <= PC + IR[11:0], 12-bit wrap.
- state  out  3  current state encoding.
- halted  out  1  in HALT.
- error  out  1  in ERROR.
- instr_count  out  CNT_W  retired instructions.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7.
- **IDLE:** if run or step is high, go to FETCH and latch step_mode = step & ~run.
- **FETCH:** hold imem_req. When imem_ready is high, assert ir_load in that cycle and go to DECODE.
- **DECODE:** one cycle.
  - dec_halt -> HALT.
  - dec_mem_read & dec_mem_write -> ERROR.
  - otherwise -> EXEC.
- **EXEC:** assert flag_we = dec_comparator.
  - Memory op -> MEM.
  - Otherwise dec_reg_write -> WB.
  - Otherwise the instruction retires in this cycle.
- **MEM:** hold dmem_req, with dmem_we = dec_mem_write. On dmem_ready:
  - dec_mem_read & dec_reg_write -> WB.
  - Otherwise the instruction retires in this cycle.
- **WB:** assert reg_we for one cycle, then retire.
- **Retire cycle:**
  - Assert exactly one of pc_load_rel (dec_pc_select & jump_ok) or pc_inc.
  - instr_count += 1, wrapping at 2^CNT_W.
  - Next state is FETCH if run & ~step_mode, else IDLE.
- **Timeout:** the wait counter resets on entry to FETCH/MEM. If it reaches MEM_TIMEOUT without ready, go to ERROR with no strobes issued.
- **Terminal states:** HALT and ERROR exit only via reset. All strobes stay 0 in both.
- **run falling mid-instruction:** the instruction completes and retires, then the FSM goes to IDLE. Instructions are never aborted.
- **Decoded inputs:** dec_* and jump_ok must be stable from DECODE through retire; they are sampled combinationally.

## Timing
- **Reset:** reset_n low forces state=IDLE immediately. All strobes, halted, error and instr_count read 0, as do step_mode and the wait counter.
- **Strobe timing:** strobes are combinational from state and inputs. The datapath samples them on the rising edge that ends the cycle.
- **Cycle counts**, zero-wait memories, IDLE excluded:
  - ALU/register op: 4 (F, D, E, W).
  - Load: 5 (F, D, E, M, W).
  - Store: 4 (F, D, E, M).
  - Compare or jump: 3 (F, D, E).
- **Wait states:** each wait cycle with ready low adds one cycle.
- **Single pulses:** ir_load, flag_we, reg_we, pc_inc and pc_load_rel are each high for at most one cycle per instruction.
- **Back-to-back:** with run held high, the cycle after retire is FETCH, with no bubble.

## Test plan
- Reset mid-MEM (dmem_req=1), reset_n low for 1 cycle -> state=0, all outputs 0, instr_count=0 on the same cycle.
- run=1, zero-wait, ALU op (dec_reg_write=1) -> strobe sequence imem_req, ir_load, -, reg_we+pc_inc; 4 cycles; instr_count=1; 5th cycle state=FETCH.
- Load, dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then reg_we; total 8 cycles.
- Jump with dec_pc_select=1: jump_ok=1 -> pc_load_rel=1, pc_inc=0 on cycle 3. Repeat with jump_ok=0 -> pc_inc=1 instead.
- step pulse, run=0 -> exactly one retire, back to IDLE, instr_count=1. dec_halt=1 -> halted=1 and stays high despite run/step.
- MEM_TIMEOUT=15, imem_ready never asserted -> ERROR after 15 FETCH cycles, error=1, ir_load never asserted. dec_mem_read=dec_mem_write=1 -> ERROR from DECODE.
